// File: rtl/pcler8_pkg.sv
// Shared definitions for the pcler8 down-counter: default sizes and the
// counter operation decode used by the top-level datapath.
package pcler8_pkg;

    localparam int WIDTH_DEF = 8;
    localparam logic [WIDTH_DEF-1:0] RELOAD_RST_DEF = 8'hFF;

    typedef enum logic [2:0] {
        OP_HOLD,
        OP_LOAD,
        OP_CLR,
        OP_DEC,
        OP_RELOAD
    } cnt_op_e;

    // Load beats clear beats count; an enabled decrement at zero becomes a reload.
    function automatic cnt_op_e decode_op(input logic ld,
                                          input logic clr,
                                          input logic en,
                                          input logic is_zero);
        cnt_op_e op;
        if (ld) begin
            op = OP_LOAD;
        end else if (clr) begin
            op = OP_CLR;
        end else if (en && !is_zero) begin
            op = OP_DEC;
        end else if (en) begin
            op = OP_RELOAD;
        end else begin
            op = OP_HOLD;
        end
        return op;
    endfunction

endpackage

// File: rtl/pcler8_evt_slot.sv
// One-entry valid/ready holder for expiry events, with a sticky overrun flag
// raised when a new expiry arrives while the previous one is still unaccepted.
module pcler8_evt_slot
    import pcler8_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic term,
    input  logic evt_ready,
    input  logic clr,
    output logic evt_valid,
    output logic evt_ovf
);

    logic valid_q, valid_d;
    logic ovf_q, ovf_d;

    // A new expiry always leaves an event pending; an accept only empties the
    // slot when no new expiry refills it on the same edge.
    always_comb begin
        valid_d = valid_q;
        ovf_d   = ovf_q;
        if (term) begin
            valid_d = 1'b1;
            if (valid_q && !evt_ready) begin
                ovf_d = 1'b1;
            end
        end else if (valid_q && evt_ready) begin
            valid_d = 1'b0;
        end
        if (clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign evt_valid = valid_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: rtl/pcler8_down_ctr.sv
// Loadable auto-reload down-counter used as a prescaler/interval timer; each
// expiry produces a one-cycle tc pulse and an event for a handshaking consumer.
module pcler8_down_ctr
    import pcler8_pkg::*;
#(
    parameter int               WIDTH      = WIDTH_DEF,
    parameter logic [WIDTH-1:0] RELOAD_RST = WIDTH'(RELOAD_RST_DEF)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             clr,
    input  logic             en,
    input  logic             rld_we,
    input  logic [WIDTH-1:0] rld_data,
    output logic [WIDTH-1:0] cnt,
    output logic [WIDTH-1:0] rld,
    output logic             tc,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic             evt_ovf
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    cnt_op_e          op;
    logic             term;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] rld_q, rld_d;
    logic             tc_q;

    // Reload reads rld_q, so a reload-register write on the same edge only
    // takes effect from the following expiry.
    always_comb begin
        op    = decode_op(ld, clr, en, cnt_q == '0);
        term  = (op == OP_RELOAD);
        cnt_d = cnt_q;
        rld_d = rld_we ? rld_data : rld_q;
        case (op)
            OP_LOAD:   cnt_d = ld_data;
            OP_CLR:    cnt_d = '0;
            OP_DEC:    cnt_d = cnt_q - ONE;
            OP_RELOAD: cnt_d = rld_q;
            default:   cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            rld_q <= RELOAD_RST;
            tc_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            rld_q <= rld_d;
            tc_q  <= term;
        end
    end

    pcler8_evt_slot u_evt_slot (
        .clk       (clk),
        .rst       (rst),
        .term      (term),
        .evt_ready (evt_ready),
        .clr       (clr),
        .evt_valid (evt_valid),
        .evt_ovf   (evt_ovf)
    );

    assign cnt = cnt_q;
    assign rld = rld_q;
    assign tc  = tc_q;

endmodule

// File: tb/tb_pcler8_down_ctr.sv
// Directed scoreboard bench for pcler8_down_ctr: each step pushes the expected
// post-edge state and the value is popped and compared after the edge.
module tb_pcler8_down_ctr;

    typedef struct {
        string      tag;
        logic [7:0] cnt;
        logic [7:0] rld;
        logic       tc;
        logic       valid;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld;
    logic [7:0] ld_data;
    logic       clr;
    logic       en;
    logic       rld_we;
    logic [7:0] rld_data;
    logic [7:0] cnt;
    logic [7:0] rld;
    logic       tc;
    logic       evt_valid;
    logic       evt_ready;
    logic       evt_ovf;

    exp_t sb[$];
    int   nAssert = 0;
    int   nFail   = 0;

    pcler8_down_ctr #(.WIDTH(8), .RELOAD_RST(8'hFF)) dut (
        .clk       (clk),
        .rst       (rst),
        .ld        (ld),
        .ld_data   (ld_data),
        .clr       (clr),
        .en        (en),
        .rld_we    (rld_we),
        .rld_data  (rld_data),
        .cnt       (cnt),
        .rld       (rld),
        .tc        (tc),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: run did not complete, observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkField(input string tag, input string field,
                              input logic [7:0] obs, input logic [7:0] exp);
        nAssert++;
        assert (obs === exp) else begin
            nFail++;
            $error("[TB] FAIL %s.%s observed=%h expected=%h", tag, field, obs, exp);
        end
    endtask

    task automatic pushExpected(input string tag, input logic [7:0] eCnt, input logic [7:0] eRld,
                                input logic eTc, input logic eValid, input logic eOvf);
        exp_t e;
        e.tag   = tag;
        e.cnt   = eCnt;
        e.rld   = eRld;
        e.tc    = eTc;
        e.valid = eValid;
        e.ovf   = eOvf;
        sb.push_back(e);
    endtask

    task automatic applyStimulus(input string tag, input logic iLd, input logic [7:0] iLdData,
                                 input logic iClr, input logic iEn, input logic iRldWe,
                                 input logic [7:0] iRldData, input logic iReady,
                                 input logic [7:0] eCnt, input logic [7:0] eRld,
                                 input logic eTc, input logic eValid, input logic eOvf);
        ld        = iLd;
        ld_data   = iLdData;
        clr       = iClr;
        en        = iEn;
        rld_we    = iRldWe;
        rld_data  = iRldData;
        evt_ready = iReady;
        pushExpected(tag, eCnt, eRld, eTc, eValid, eOvf);
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            nAssert++;
            nFail++;
            $display("[TB] FAIL scoreboard: observed empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            checkField(e.tag, "cnt", cnt, e.cnt);
            checkField(e.tag, "rld", rld, e.rld);
            checkField(e.tag, "tc", {7'd0, tc}, {7'd0, e.tc});
            checkField(e.tag, "evt_valid", {7'd0, evt_valid}, {7'd0, e.valid});
            checkField(e.tag, "evt_ovf", {7'd0, evt_ovf}, {7'd0, e.ovf});
        end
    endtask

    task automatic runStep(input string tag, input logic iLd, input logic [7:0] iLdData,
                           input logic iClr, input logic iEn, input logic iRldWe,
                           input logic [7:0] iRldData, input logic iReady,
                           input logic [7:0] eCnt, input logic [7:0] eRld,
                           input logic eTc, input logic eValid, input logic eOvf);
        applyStimulus(tag, iLd, iLdData, iClr, iEn, iRldWe, iRldData, iReady,
                      eCnt, eRld, eTc, eValid, eOvf);
        @(posedge clk);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus("reset", 0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;

        // Load and count through the terminal count.
        runStep("load3",   1, 8'h03, 0, 0, 0, 8'h00, 0, 8'h03, 8'hFF, 0, 0, 0);
        runStep("dec2",    0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h02, 8'hFF, 0, 0, 0);
        runStep("dec1",    0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h01, 8'hFF, 0, 0, 0);
        runStep("dec0",    0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        runStep("reload",  0, 8'h00, 0, 1, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 1, 0);
        runStep("decFE",   0, 8'h00, 0, 1, 0, 8'h00, 0, 8'hFE, 8'hFF, 0, 1, 0);

        // Priority ld > clr > en.
        runStep("prio_ld",  1, 8'h5A, 1, 1, 0, 8'h00, 0, 8'h5A, 8'hFF, 0, 1, 0);
        runStep("prio_clr", 0, 8'h00, 1, 1, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 1, 0);
        runStep("accept",   0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'hFF, 0, 0, 0);

        // Reload write racing a terminal count uses the old reload value.
        runStep("wr_rld10", 0, 8'h00, 0, 0, 1, 8'h10, 0, 8'h00, 8'h10, 0, 0, 0);
        runStep("race",     0, 8'h00, 0, 1, 1, 8'h20, 0, 8'h10, 8'h20, 1, 1, 0);
        for (int i = 1; i <= 16; i++) begin
            runStep("race_dec", 0, 8'h00, 0, 1, 0, 8'h00, 1, 8'(16 - i), 8'h20, 0, 0, 0);
        end
        runStep("race_term", 0, 8'h00, 0, 1, 0, 8'h00, 1, 8'h20, 8'h20, 1, 1, 0);

        // Expiry and accept on the same edge.
        runStep("rld0",        0, 8'h00, 0, 0, 1, 8'h00, 0, 8'h20, 8'h00, 0, 1, 0);
        runStep("clr",         0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1, 0);
        runStep("term_accept", 0, 8'h00, 0, 1, 0, 8'h00, 1, 8'h00, 8'h00, 1, 1, 0);

        // Overrun with reload of zero and a stalled consumer.
        runStep("drain",   0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 0);
        runStep("hs_t1",   0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 0);
        runStep("hs_t2",   0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1);
        runStep("hs_t3",   0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1);
        runStep("hs_acc",  0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1);
        runStep("hs_idle", 0, 8'h00, 0, 0, 0, 8'h00, 1, 8'h00, 8'h00, 0, 0, 1);
        runStep("hs_clr",  0, 8'h00, 1, 0, 0, 8'h00, 0, 8'h00, 8'h00, 0, 0, 0);

        // Asynchronous reset mid-count with an event and overrun pending.
        runStep("pre_t1", 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 0);
        runStep("pre_t2", 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'h00, 8'h00, 1, 1, 1);
        runStep("ld5",    1, 8'h05, 0, 0, 0, 8'h00, 0, 8'h05, 8'h00, 0, 1, 1);
        #3;
        en  = 1'b1;
        rst = 1'b1;
        pushExpected("async_rst", 8'h00, 8'hFF, 0, 0, 0);
        #1;
        checkOutput();
        pushExpected("rst_hold", 8'h00, 8'hFF, 0, 0, 0);
        @(posedge clk);
        #1;
        checkOutput();
        rst = 1'b0;
        runStep("post_rst",     0, 8'h00, 0, 0, 0, 8'h00, 0, 8'h00, 8'hFF, 0, 0, 0);
        runStep("post_rst_dec", 0, 8'h00, 0, 1, 0, 8'h00, 0, 8'hFF, 8'hFF, 1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/pcler8_down_ctr.md
Name: pcler8_down_ctr

Overview:
- Decrementing counterpart of the team's 8-bit load/clear/up-count auto-reload counter.
- Loadable WIDTH-bit down-counter with clear, count enable and a reload register.
- On terminal count (enabled decrement at zero) it reloads, emits a one-cycle tc pulse, and posts an event through a valid/ready handshake with sticky overrun.
- Used as a prescaler/interval timer feeding a consumer that acknowledges each expiry.

Parameters:
- WIDTH, 8, counter and reload register width.
- RELOAD_RST, 8'hFF, reset value of the reload register (WIDTH bits).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ld  in  1  synchronous parallel load of cnt from ld_data.
- ld_data  in  WIDTH  load value.
- clr  in  1  synchronous clear of cnt to 0; also clears evt_ovf.
- en  in  1  count enable (decrement).
- rld_we  in  1  write enable for reload register.
- rld_data  in  WIDTH  reload register write value.
- cnt  out  WIDTH  current count (registered).
- rld  out  WIDTH  current reload register value.
- tc  out  1  registered one-cycle pulse: terminal count occurred on the previous edge.
- evt_valid  out  1  expiry event pending.
- evt_ready  in  1  consumer accepts the event.
- evt_ovf  out  1  sticky: an expiry was lost while evt_valid was pending and not accepted.

Behaviour:
- Reset (async, rst=1): cnt=0, rld=RELOAD_RST, tc=0, evt_valid=0, evt_ovf=0. Outputs hold while rst is high; release is synchronous to the next edge.
- Counter next state, priority ld > clr > en:
  - ld=1: cnt<=ld_data; no terminal count.
  - else clr=1: cnt<=0; no terminal count.
  - else en=1 and cnt!=0: cnt<=cnt-1.
  - else en=1 and cnt==0 (terminal count, "term"): cnt<=rld; term=1.
  - else hold.
- Wrap never underflows to all-ones. cnt reloads from rld; rld=0 gives a term on every enabled cycle.
- Reload register: rld_we=1 updates rld on the edge. On a simultaneous term, the reload uses the pre-write (old) rld value; the new value applies from the next term.
- tc<=term every cycle, so tc is high exactly one cycle after each term edge, and high on consecutive cycles when term repeats.
- Event handshake: a transfer is evt_valid & evt_ready on an edge.
  - term & !evt_valid: evt_valid<=1.
  - term & evt_valid & evt_ready: evt_valid stays 1 (old event consumed, new one posted); no overrun.
  - term & evt_valid & !evt_ready: evt_valid stays 1; evt_ovf<=1.
  - !term & transfer: evt_valid<=0.
  - evt_valid must not drop without a transfer; evt_ready while evt_valid=0 is ignored.
- evt_ovf clears only on rst or clr. If clr and a set condition coincide, clr wins (term cannot occur on a clr cycle anyway). clr does not affect evt_valid.
- Latency: ld/clr/en to cnt is 1 edge. term to tc/evt_valid is 1 edge.
- Reset mid-operation returns everything to reset values immediately, including a pending event.

Decomposition:
- Shared package pcler8_pkg:
  - WIDTH default constant.
  - RELOAD_RST default.
  - cnt_op enum {OP_HOLD, OP_LOAD, OP_CLR, OP_DEC, OP_RELOAD}, decoded from ld/clr/en/cnt==0.
- Sub-module pcler8_evt_slot: one-entry valid/ready event holder with overrun flag. Inputs: term, evt_ready, clr. Outputs: evt_valid, evt_ovf.
- Counter datapath and op decode stay in the top module.

Test Plan:
- Reset: assert rst mid-count with cnt=8'h05 -> cnt=0, rld=8'hFF, tc=0, evt_valid=0, evt_ovf=0 immediately, without waiting for a clock edge.
- Load and count: ld_data=8'h03, ld pulse, then en=1 held -> cnt 3,2,1,0,FF(reload); tc high for exactly one cycle after the 0->FF edge; evt_valid=1.
- Priority: ld=1, clr=1, en=1 with ld_data=8'h5A -> cnt=8'h5A. Next cycle clr=1, en=1 -> cnt=0, no tc.
- Reload write race: cnt=0, rld=8'h10, en=1 with rld_we=1, rld_data=8'h20 on the same edge -> cnt=8'h10, rld=8'h20. Count down to the next term -> cnt=8'h20.
- Handshake: rld=0, en=1, evt_ready=0 -> evt_valid=1 after the first term, evt_ovf=1 after the second term, tc high continuously. Then evt_ready=1 with en=0 -> evt_valid drops after one edge; evt_ovf stays 1 until a clr pulse clears it.
- Simultaneous term and accept: evt_valid=1, evt_ready=1 on a term edge -> evt_valid remains 1, evt_ovf remains 0.
